// File: rtl/breath_led_array.sv
`default_nettype none
// ============================================================================
// Module  : breath_led_array
// Brief   : CH_NUM-channel PWM LED engine (off/on/breathe/blink), active-low
//           registered outputs. Optional macro BREATH_GAMMA_EN: squared duty
//           curve through a registered multiply (+1 clk output latency).
// Rev     : 1.0
// ============================================================================
module breath_led_array #(
    parameter int  CH_NUM        = 4,
    parameter int  PWM_W         = 12,
    parameter int  HOLD_PERIODS  = 64,
    parameter int  BLINK_PERIODS = 1024,
    parameter int  DEF_MODE      = 2,
    parameter int  DEF_STEP      = 1,
    localparam int CH_W          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [7:0]        cfg_step,
    output logic              period_tick,
    output logic [CH_NUM-1:0] led
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_BLINK   = 2'd3;

    localparam int HC_MAX  = (HOLD_PERIODS > BLINK_PERIODS) ? HOLD_PERIODS : BLINK_PERIODS;
    localparam int HC_W    = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;
    localparam int ARITH_W = ((PWM_W > 8) ? PWM_W : 8) + 1;
    localparam int SQ_W    = 2 * PWM_W;

    localparam logic [PWM_W-1:0]   LMAX       = {PWM_W{1'b1}};
    localparam logic [ARITH_W-1:0] LMAX_EXT   = ARITH_W'(LMAX);
    localparam logic [HC_W-1:0]    HOLD_LAST  = HC_W'(HOLD_PERIODS - 1);
    localparam logic [HC_W-1:0]    BLINK_LAST = HC_W'(BLINK_PERIODS - 1);

    typedef enum logic [2:0] {
        ST_RISE    = 3'd0,
        ST_HOLD_HI = 3'd1,
        ST_FALL    = 3'd2,
        ST_HOLD_LO = 3'd3,
        ST_BLK_LO  = 3'd4,
        ST_BLK_HI  = 3'd5
    } state_t;

    localparam state_t ST_DEF = (DEF_MODE == 3) ? ST_BLK_LO : ST_RISE;

    logic [PWM_W-1:0]  pwm_cnt_q;
    logic [PWM_W-1:0]  w_pwm_cmp;
    logic [CH_NUM-1:0] w_led_d;
    logic [CH_NUM-1:0] led_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            led_q     <= '1;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            led_q     <= w_led_d;
        end
    end

    assign period_tick = (pwm_cnt_q == LMAX);
    assign led         = led_q;

`ifdef BREATH_GAMMA_EN
    // Carrier delayed to line up with the registered squared duty.
    logic [PWM_W-1:0] pwm_dly_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pwm_dly_q <= '0;
        else      pwm_dly_q <= pwm_cnt_q;
    end
    assign w_pwm_cmp = pwm_dly_q;
`else
    assign w_pwm_cmp = pwm_cnt_q;
`endif

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [1:0]         mode_q,  mode_d;
        logic [7:0]         step_q,  step_d;
        logic [PWM_W-1:0]   level_q, level_d;
        logic [HC_W-1:0]    hold_q,  hold_d;
        state_t             state_q, state_d;
        logic               w_wr_hit;
        logic [7:0]         w_step8;
        logic [ARITH_W-1:0] w_lvl, w_step, w_sum, w_diff;
        logic [1:0]         w_omode;
        logic               w_ohi;
        logic [PWM_W-1:0]   w_oduty;
        logic               w_led_bit;

        assign w_wr_hit = cfg_wr && (cfg_ch == CH_W'(i));
        assign w_step8  = (step_q == 8'd0) ? 8'd1 : step_q;
        assign w_lvl    = ARITH_W'(level_q);
        assign w_step   = ARITH_W'(w_step8);
        assign w_sum    = w_lvl + w_step;
        assign w_diff   = w_lvl - w_step;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode_q  <= 2'(DEF_MODE);
                step_q  <= 8'(DEF_STEP);
                level_q <= '0;
                hold_q  <= '0;
                state_q <= ST_DEF;
            end else begin
                mode_q  <= mode_d;
                step_q  <= step_d;
                level_q <= level_d;
                hold_q  <= hold_d;
                state_q <= state_d;
            end
        end

        // A config write restarts the channel and pre-empts a same-cycle tick.
        always_comb begin
            mode_d  = mode_q;
            step_d  = step_q;
            level_d = level_q;
            hold_d  = hold_q;
            state_d = state_q;
            if (w_wr_hit) begin
                mode_d  = cfg_mode;
                step_d  = cfg_step;
                level_d = '0;
                hold_d  = '0;
                state_d = (cfg_mode == MODE_BLINK) ? ST_BLK_LO : ST_RISE;
            end else if (period_tick && (mode_q == MODE_BREATHE || mode_q == MODE_BLINK)) begin
                case (state_q)
                    ST_RISE: begin
                        if (w_sum >= LMAX_EXT) begin
                            level_d = LMAX;
                            hold_d  = '0;
                            state_d = (HOLD_PERIODS == 0) ? ST_FALL : ST_HOLD_HI;
                        end else begin
                            level_d = PWM_W'(w_sum);
                        end
                    end
                    ST_HOLD_HI, ST_HOLD_LO: begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = '0;
                            state_d = (state_q == ST_HOLD_HI) ? ST_FALL : ST_RISE;
                        end else begin
                            hold_d = hold_q + HC_W'(1);
                        end
                    end
                    ST_FALL: begin
                        if (w_lvl <= w_step) begin
                            level_d = '0;
                            hold_d  = '0;
                            state_d = (HOLD_PERIODS == 0) ? ST_RISE : ST_HOLD_LO;
                        end else begin
                            level_d = PWM_W'(w_diff);
                        end
                    end
                    ST_BLK_LO, ST_BLK_HI: begin
                        if (hold_q == BLINK_LAST) begin
                            hold_d  = '0;
                            state_d = (state_q == ST_BLK_LO) ? ST_BLK_HI : ST_BLK_LO;
                        end else begin
                            hold_d = hold_q + HC_W'(1);
                        end
                    end
                    default: state_d = ST_RISE;
                endcase
            end
        end

`ifdef BREATH_GAMMA_EN
        logic [SQ_W-1:0]  w_sq;
        logic [1:0]       omode_q;
        logic             ohi_q;
        logic [PWM_W-1:0] oduty_q;

        assign w_sq = SQ_W'(level_q) * SQ_W'(level_q);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                omode_q <= MODE_OFF;
                ohi_q   <= 1'b0;
                oduty_q <= '0;
            end else begin
                omode_q <= mode_q;
                ohi_q   <= (state_q == ST_BLK_HI);
                oduty_q <= PWM_W'(w_sq >> PWM_W);
            end
        end

        assign w_omode = omode_q;
        assign w_ohi   = ohi_q;
        assign w_oduty = oduty_q;
`else
        assign w_omode = mode_q;
        assign w_ohi   = (state_q == ST_BLK_HI);
        assign w_oduty = level_q;
`endif

        always_comb begin
            w_led_bit = 1'b1;
            case (w_omode)
                MODE_OFF:   w_led_bit = 1'b1;
                MODE_ON:    w_led_bit = 1'b0;
                MODE_BLINK: w_led_bit = ~w_ohi;
                default:    w_led_bit = (w_pwm_cmp < w_oduty) ? 1'b0 : 1'b1;
            endcase
        end

        assign w_led_d[i] = w_led_bit;
    end

endmodule
`default_nettype wire

// File: tb/tb_breath_led_array.sv
`default_nettype none
// tb_breath_led_array: directed and random config traffic checked every clk
// against a period-level model (level looked up from a per-step sequence).
module tb_breath_led_array;

    localparam int CH_NUM = 3;
    localparam int PWM_W  = 4;
    localparam int HOLD   = 2;
    localparam int BLINK  = 3;
    localparam int PER    = 16;
    localparam int LMAX   = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_wr;
    logic [1:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [7:0]        cfg_step;
    logic              period_tick;
    logic [CH_NUM-1:0] led;

    breath_led_array #(
        .CH_NUM(CH_NUM), .PWM_W(PWM_W), .HOLD_PERIODS(HOLD),
        .BLINK_PERIODS(BLINK), .DEF_MODE(2), .DEF_STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step),
        .period_tick(period_tick), .led(led)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int                pwm_m;
    int                mode_m [CH_NUM];
    int                step_m [CH_NUM];
    int                n_m    [CH_NUM];
    logic [CH_NUM-1:0] pipe_m;
    logic [CH_NUM-1:0] led_s;

    // Level after n ticks since restart: one breathing cycle laid out as a list.
    function automatic int level_of(int s, int n);
        int q[$];
        int se;
        se = (s == 0) ? 1 : s;
        q.push_back(0);
        for (int v = se; v < LMAX; v += se) q.push_back(v);
        for (int k = 0; k <= HOLD; k++) q.push_back(LMAX);
        for (int v = LMAX - se; v > 0; v -= se) q.push_back(v);
        for (int k = 0; k < HOLD; k++) q.push_back(0);
        return q[n % q.size()];
    endfunction

    function automatic int duty_of(int l);
`ifdef BREATH_GAMMA_EN
        return (l * l) >> PWM_W;
`else
        return l;
`endif
    endfunction

    function automatic logic exp_bit(int c);
        case (mode_m[c])
            0:       return 1'b1;
            1:       return 1'b0;
            3:       return (((n_m[c] / BLINK) % 2) == 0) ? 1'b1 : 1'b0;
            default: return (pwm_m < duty_of(level_of(step_m[c], n_m[c]))) ? 1'b0 : 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        pwm_m  = 0;
        pipe_m = '1;
        for (int c = 0; c < CH_NUM; c++) begin
            mode_m[c] = 2;
            step_m[c] = 1;
            n_m[c]    = 0;
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic run_cycle();
        logic [CH_NUM-1:0] nxt;
        logic [CH_NUM-1:0] exp_led;
        logic              exp_tick;
        exp_tick = rst && (pwm_m == LMAX);
        n_assert++;
        assert (period_tick === exp_tick) else begin
            n_fail++;
            $error("FAIL period_tick pwm=%0d got %b exp %b", pwm_m, period_tick, exp_tick);
        end
        for (int c = 0; c < CH_NUM; c++) nxt[c] = rst ? exp_bit(c) : 1'b1;
`ifdef BREATH_GAMMA_EN
        exp_led = rst ? pipe_m : '1;
        pipe_m  = nxt;
`else
        exp_led = nxt;
`endif
        @(posedge clk);
        #1;
        led_s = led;
        n_assert++;
        assert (led === exp_led) else begin
            n_fail++;
            $error("FAIL led pwm=%0d got %b exp %b", pwm_m, led, exp_led);
        end
        if (rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (cfg_wr && int'(cfg_ch) == c) begin
                    mode_m[c] = int'(cfg_mode);
                    step_m[c] = int'(cfg_step);
                    n_m[c]    = 0;
                end else if (exp_tick) begin
                    n_m[c]++;
                end
            end
            pwm_m = (pwm_m + 1) % PER;
        end
        cfg_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(int ch, int mode, int step);
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_step = 8'(step);
        cfg_wr   = 1'b1;
        run_cycle();
    endtask

    task automatic run_n(int n);
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    task automatic wait_tick_next();
        int guard;
        guard = 0;
        while (pwm_m != LMAX && guard < 2 * PER) begin
            run_cycle();
            guard++;
        end
        n_assert++;
        assert (pwm_m == LMAX) else begin
            n_fail++;
            $error("FAIL wait_tick bound got %0d exp %0d", pwm_m, LMAX);
        end
    endtask

    initial begin
        int guard;
        int lows;
        rst      = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_mode = '0;
        cfg_step = '0;
        model_reset();
        @(posedge clk);
        #1;
        n_assert++;
        assert (led === 3'b111) else begin
            n_fail++;
            $error("FAIL reset_led got %b exp %b", led, 3'b111);
        end
        @(negedge clk);
        run_n(5);
        rst = 1'b1;

        // Duty while ch0 sits at level 5 for a whole carrier period.
        guard = 0;
        while (!(level_of(step_m[0], n_m[0]) == 5 && pwm_m == 0) && guard < 2000) begin
            run_cycle();
            guard++;
        end
        lows = 0;
        for (int k = 0; k < PER; k++) begin
            run_cycle();
            if (led_s[0] == 1'b0) lows++;
        end
        n_assert++;
        assert (lows == duty_of(5)) else begin
            n_fail++;
            $error("FAIL duty_level5 got %0d exp %0d", lows, duty_of(5));
        end
        run_n(560);

        do_write(1, 2, 4);
        run_n(300);
        do_write(1, 2, 0);
        run_n(100);

        do_write(2, 3, 1);
        run_n(250);

        wait_tick_next();
        do_write(0, 1, 0);
        run_n(40);
        wait_tick_next();
        do_write(1, 2, 3);
        run_n(100);

        do_write(3, 0, 5);
        run_n(50);
        do_write(0, 0, 1);
        run_n(50);

        do_write(0, 2, 1);
        guard = 0;
        while (level_of(step_m[0], n_m[0]) != 9 && guard < 1000) begin
            run_cycle();
            guard++;
        end
        #2;
        rst = 1'b0;
        #1;
        n_assert++;
        assert (led === 3'b111) else begin
            n_fail++;
            $error("FAIL async_reset_led got %b exp %b", led, 3'b111);
        end
        model_reset();
        run_n(3);
        rst = 1'b1;
        run_n(200);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_ch   = 2'($urandom_range(0, 3));
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_step = 8'($urandom_range(0, 16));
                cfg_wr   = 1'b1;
            end
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
